// File: rtl/sram_1r1w_ctrl.sv
// Requester-side controller for a 1R1W SRAM macro: post-reset zero fill,
// decoupled read/write ports, write-to-read bypass and a held read response.
module sram_1r1w_ctrl #(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 7,
  parameter int WIDTH   = 51,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_resp_valid,
  output logic [WIDTH-1:0]  r_resp_data,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [WIDTH-1:0]  w_req_data,
  output logic              init_done,
  output logic              sram_r_en,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [WIDTH-1:0]  sram_r_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [WIDTH-1:0]  sram_w_data
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] init_cnt_r;
  logic              init_done_r;
  logic              resp_valid_r;
  logic              bypass_r;
  logic [WIDTH-1:0]  bypass_data_r;
  logic [WIDTH-1:0]  hold_r;

  logic              ready_s;
  logic              init_wr_s;
  logic              r_fire_s;
  logic              w_fire_s;
  logic [WIDTH-1:0]  resp_data_s;

  // Everything is gated by reset_n so the macro sees no enables while reset is held.
  assign ready_s   = reset_n && (state_r == ST_READY);
  assign init_wr_s = reset_n && (state_r == ST_INIT);
  assign r_fire_s  = ready_s && r_req_valid;
  assign w_fire_s  = ready_s && w_req_valid;

  assign r_req_ready  = ready_s;
  assign w_req_ready  = ready_s;
  assign r_resp_valid = reset_n && resp_valid_r;
  assign r_resp_data  = reset_n ? resp_data_s : {WIDTH{1'b0}};
  assign init_done    = reset_n && (init_done_r || (INIT_EN == 1'b0));

  // Macro port drive and response data selection.
  always_comb begin
    sram_w_en   = 1'b0;
    sram_w_addr = {ADDR_W{1'b0}};
    sram_w_data = {WIDTH{1'b0}};
    sram_r_en   = 1'b0;
    sram_r_addr = {ADDR_W{1'b0}};
    resp_data_s = hold_r;
    if (init_wr_s) begin
      sram_w_en   = 1'b1;
      sram_w_addr = init_cnt_r;
    end else if (w_fire_s) begin
      sram_w_en   = 1'b1;
      sram_w_addr = w_req_addr;
      sram_w_data = w_req_data;
    end else begin
      sram_w_en   = 1'b0;
    end
    if (r_fire_s) begin
      sram_r_en   = 1'b1;
      sram_r_addr = r_req_addr;
    end else begin
      sram_r_en   = 1'b0;
    end
    // Response cycle: the bypass wins over the macro, whose read saw the old data.
    if (resp_valid_r) begin
      if (bypass_r) begin
        resp_data_s = bypass_data_r;
      end else begin
        resp_data_s = sram_r_data;
      end
    end else begin
      resp_data_s = hold_r;
    end
  end

  // Clear sequencer, response pipeline, bypass capture and hold register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r       <= INIT_EN ? ST_INIT : ST_READY;
      init_cnt_r    <= {ADDR_W{1'b0}};
      init_done_r   <= 1'b0;
      resp_valid_r  <= 1'b0;
      bypass_r      <= 1'b0;
      bypass_data_r <= {WIDTH{1'b0}};
      hold_r        <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + ADDR_W'(1);
          if (init_cnt_r == ADDR_W'(DEPTH - 1)) begin
            state_r     <= ST_READY;
            init_done_r <= 1'b1;
          end
        end
        ST_READY: begin
          state_r <= ST_READY;
        end
        default: begin
          state_r <= ST_READY;
        end
      endcase
      resp_valid_r <= r_fire_s;
      bypass_r     <= r_fire_s && w_fire_s && (r_req_addr == w_req_addr);
      if (r_fire_s && w_fire_s) begin
        bypass_data_r <= w_req_data;
      end
      if (resp_valid_r) begin
        hold_r <= resp_data_s;
      end
    end
  end

endmodule

// File: tb/tb_sram_1r1w_ctrl.sv
// Self-checking bench for sram_1r1w_ctrl: a behavioural SRAM macro plus an
// array-based reference of the stored contents and expected responses.
module tb_sram_1r1w_ctrl;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int W     = 51;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          r_req_valid, r_req_ready, r_resp_valid;
  logic [AW-1:0] r_req_addr;
  logic [W-1:0]  r_resp_data;
  logic          w_req_valid, w_req_ready;
  logic [AW-1:0] w_req_addr;
  logic [W-1:0]  w_req_data;
  logic          init_done;
  logic          sram_r_en, sram_w_en;
  logic [AW-1:0] sram_r_addr, sram_w_addr;
  logic [W-1:0]  sram_r_data, sram_w_data;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] macro_mem [DEPTH];
  logic         seed_en;
  logic [W-1:0] ref_mem [DEPTH];
  logic         exp_valid;
  logic [W-1:0] exp_data;
  logic         obs_r_en, obs_w_en, obs_ready;
  logic [AW-1:0] obs_r_addr, obs_w_addr;
  logic [W-1:0] obs_w_data;

  always #5 clock = ~clock;

  sram_1r1w_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
    .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data),
    .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_addr(w_req_addr),
    .w_req_data(w_req_data), .init_done(init_done),
    .sram_r_en(sram_r_en), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
    .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data)
  );

  // Behavioural macro: registered read address, read returns old data on collision.
  always @(posedge clock) begin
    if (seed_en) begin
      for (int i = 0; i < DEPTH; i++) macro_mem[i] <= {$urandom(), $urandom()};
    end else begin
      if (sram_w_en) macro_mem[sram_w_addr] <= sram_w_data;
      if (sram_r_en) sram_r_data <= macro_mem[sram_r_addr];
    end
  end

  function automatic logic [W-1:0] rand_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // One request cycle, driven at the falling edge; the model predicts what the
  // response port shows after the next rising edge.
  task automatic step(input bit rv, input logic [AW-1:0] ra,
                      input bit wv, input logic [AW-1:0] wa, input logic [W-1:0] wd);
    r_req_valid = rv; r_req_addr = ra;
    w_req_valid = wv; w_req_addr = wa; w_req_data = wd;
    #1;
    obs_r_en = sram_r_en; obs_r_addr = sram_r_addr;
    obs_w_en = sram_w_en; obs_w_addr = sram_w_addr; obs_w_data = sram_w_data;
    obs_ready = r_req_ready & w_req_ready;
    if (rv) exp_data = (wv && wa == ra) ? wd : ref_mem[ra];
    exp_valid = rv;
    if (wv) ref_mem[wa] = wd;
    @(posedge clock);
    @(negedge clock);
    r_req_valid = 1'b0; w_req_valid = 1'b0;
    r_req_addr = '0; w_req_addr = '0; w_req_data = '0;
  endtask

  // Releases reset and follows the clear; abort_at < DEPTH re-asserts reset there.
  task automatic run_init(input int abort_at);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == abort_at) begin
        reset_n = 1'b0;
        @(negedge clock);
        return;
      end
      #1;
      checks++;
      if (sram_w_en !== 1'b1 || sram_w_addr !== AW'(i) || sram_w_data !== '0 ||
          r_req_ready !== 1'b0 || w_req_ready !== 1'b0 || init_done !== 1'b0 || sram_r_en !== 1'b0) begin
        failures++;
        $display("FAIL init_cycle%0d: w_en=%0b w_addr=%0d w_data=%h rdy=%0b%0b done=%0b r_en=%0b, need w_en=1 addr=%0d data=0 rdy=00 done=0 r_en=0",
                 i, sram_w_en, sram_w_addr, sram_w_data, r_req_ready, w_req_ready, init_done, sram_r_en, i);
      end
      @(negedge clock);
    end
    checks++;
    if (init_done !== 1'b1 || r_req_ready !== 1'b1 || w_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL init_end: done=%0b rdy=%0b%0b, need 1 11", init_done, r_req_ready, w_req_ready);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_valid = 1'b0; exp_data = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (init_done !== 1'b0 || r_resp_valid !== 1'b0 || r_resp_data !== '0 || sram_w_en !== 1'b0 ||
        sram_r_en !== 1'b0 || r_req_ready !== 1'b0 || w_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: done=%0b rv=%0b rd=%h wen=%0b ren=%0b rdy=%0b%0b, need all 0",
               init_done, r_resp_valid, r_resp_data, sram_w_en, sram_r_en, r_req_ready, w_req_ready);
    end
  endtask

  task automatic test_read_after_init();
    step(1'b1, 7'd5, 1'b0, 7'd0, '0);
    checks++;
    if (r_resp_valid !== 1'b1 || r_resp_data !== 51'd0) begin
      failures++;
      $display("FAIL read_cleared: valid=%0b data=%h, need 1 0", r_resp_valid, r_resp_data);
    end
  endtask

  task automatic test_write_read();
    step(1'b0, 7'd0, 1'b1, 7'h12, 51'h1_2345_6789_ABCD);
    checks++;
    if (obs_w_en !== 1'b1 || obs_w_addr !== 7'h12 || obs_w_data !== 51'h1_2345_6789_ABCD) begin
      failures++;
      $display("FAIL write_drive: en=%0b addr=%h data=%h, need 1 12 12345_6789abcd", obs_w_en, obs_w_addr, obs_w_data);
    end
    step(1'b0, 7'd0, 1'b0, 7'd0, '0);
    step(1'b1, 7'h12, 1'b0, 7'd0, '0);
    checks++;
    if (obs_r_en !== 1'b1 || obs_r_addr !== 7'h12 || r_resp_valid !== 1'b1 || r_resp_data !== 51'h1_2345_6789_ABCD) begin
      failures++;
      $display("FAIL write_read: ren=%0b raddr=%h valid=%0b data=%h, need 1 12 1 12345_6789abcd",
               obs_r_en, obs_r_addr, r_resp_valid, r_resp_data);
    end
    step(1'b0, 7'd0, 1'b0, 7'd0, '0);
    checks++;
    if (r_resp_valid !== 1'b0 || r_resp_data !== 51'h1_2345_6789_ABCD || obs_r_addr !== 7'd0 || obs_w_addr !== 7'd0) begin
      failures++;
      $display("FAIL idle_after_read: valid=%0b data=%h raddr=%h waddr=%h, need 0 12345_6789abcd 0 0",
               r_resp_valid, r_resp_data, obs_r_addr, obs_w_addr);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] ones;
    ones = '1;
    step(1'b1, 7'h40, 1'b1, 7'h40, ones);
    checks++;
    if (r_resp_valid !== 1'b1 || r_resp_data !== ones) begin
      failures++;
      $display("FAIL bypass: valid=%0b data=%h, need 1 %h", r_resp_valid, r_resp_data, ones);
    end
  endtask

  task automatic test_hold();
    step(1'b0, 7'd0, 1'b1, 7'd3, 51'hAA);
    step(1'b1, 7'd3, 1'b0, 7'd0, '0);
    checks++;
    if (r_resp_valid !== 1'b1 || r_resp_data !== 51'hAA) begin
      failures++;
      $display("FAIL hold_first: valid=%0b data=%h, need 1 aa", r_resp_valid, r_resp_data);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 7'd0, 1'b1, 7'd3, 51'hBB);
      checks++;
      if (r_resp_valid !== 1'b0 || r_resp_data !== 51'hAA) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid=%0b data=%h, need 0 aa", i, r_resp_valid, r_resp_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [4];
    logic [W-1:0]  vals [4];
    addrs = '{7'd1, 7'd2, 7'd3, 7'd127};
    for (int i = 0; i < 4; i++) begin
      vals[i] = rand_data();
      step(1'b0, 7'd0, 1'b1, addrs[i], vals[i]);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, addrs[i], 1'b0, 7'd0, '0);
      checks++;
      if (r_resp_valid !== 1'b1 || r_resp_data !== vals[i]) begin
        failures++;
        $display("FAIL b2b_%0d: valid=%0b data=%h, need 1 %h", i, r_resp_valid, r_resp_data, vals[i]);
      end
    end
    step(1'b0, 7'd0, 1'b0, 7'd0, '0);
    checks++;
    if (r_resp_valid !== 1'b0 || r_resp_data !== vals[3]) begin
      failures++;
      $display("FAIL b2b_tail: valid=%0b data=%h, need 0 %h", r_resp_valid, r_resp_data, vals[3]);
    end
  endtask

  task automatic test_random();
    bit rv, wv;
    logic [AW-1:0] ra, wa;
    logic [W-1:0] wd;
    for (int n = 0; n < 300; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      wv = ($urandom_range(0, 2) != 0);
      ra = AW'($urandom_range(0, 7));
      wa = AW'($urandom_range(0, 7));
      wd = rand_data();
      step(rv, ra, wv, wa, wd);
      checks++;
      if (r_resp_valid !== exp_valid || r_resp_data !== exp_data || obs_ready !== 1'b1 ||
          obs_r_en !== rv || obs_r_addr !== (rv ? ra : 7'd0) ||
          obs_w_en !== wv || obs_w_addr !== (wv ? wa : 7'd0) || obs_w_data !== (wv ? wd : 51'd0)) begin
        failures++;
        $display("FAIL random_%0d: valid=%0b data=%h ren=%0b wen=%0b rdy=%0b, need %0b %h %0b %0b 1",
                 n, r_resp_valid, r_resp_data, obs_r_en, obs_w_en, obs_ready, exp_valid, exp_data, rv, wv);
      end
    end
  endtask

  task automatic test_reset_mid_read_and_init();
    r_req_valid = 1'b1; r_req_addr = 7'd9;
    @(posedge clock);
    @(negedge clock);
    r_req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (r_resp_valid !== 1'b0 || r_resp_data !== '0 || sram_r_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop_read: valid=%0b data=%h ren=%0b, need 0 0 0", r_resp_valid, r_resp_data, sram_r_en);
    end
    @(negedge clock);
    checks++;
    if (r_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop_read2: valid=%0b, need 0", r_resp_valid);
    end
    run_init(60);
    @(negedge clock);
    run_init(DEPTH + 1);
    test_read_after_init();
  endtask

  initial begin
    reset_n = 1'b0; seed_en = 1'b1;
    r_req_valid = 1'b0; r_req_addr = '0;
    w_req_valid = 1'b0; w_req_addr = '0; w_req_data = '0;
    exp_valid = 1'b0; exp_data = '0;
    @(negedge clock);
    @(negedge clock);
    seed_en = 1'b0;
    test_reset();
    run_init(DEPTH + 1);
    test_read_after_init();
    test_write_read();
    test_bypass();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_read_and_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_1r1w_ctrl.md
Name: sram_1r1w_ctrl

Overview:
- Requester-side controller that drives one 1R1W SRAM macro: 7-bit address, 51-bit data, registered read address, read data returned the cycle after the enable.
- Clears the whole array after reset.
- Presents decoupled read/write request ports and a read-response port to the pipeline.
- Resolves same-cycle read/write address conflicts and holds read data stable until the next accepted read.

Parameters:
DEPTH, 128, number of SRAM entries; must be a power of two
ADDR_W, 7, address width; equals log2(DEPTH)
WIDTH, 51, data width
INIT_EN, 1, 1 = zero-fill the array after reset; 0 = enter READY directly

Ports:
clock  in  1  single clock; the macro's R0_clk and W0_clk are tied to it externally
reset_n  in  1  synchronous reset, active-low
r_req_valid  in  1  read request valid
r_req_ready  out  1  read request accepted when high together with valid
r_req_addr  in  ADDR_W  read address
r_resp_valid  out  1  one-cycle pulse; read data is now valid
r_resp_data  out  WIDTH  read data; held stable until the next response
w_req_valid  in  1  write request valid
w_req_ready  out  1  write request accepted when high together with valid
w_req_addr  in  ADDR_W  write address
w_req_data  in  WIDTH  write data
init_done  out  1  high once the array is cleared (or immediately if INIT_EN=0)
sram_r_en  out  1  to macro R0_en
sram_r_addr  out  ADDR_W  to macro R0_addr
sram_r_data  in  WIDTH  from macro R0_data
sram_w_en  out  1  to macro W0_en
sram_w_addr  out  ADDR_W  to macro W0_addr
sram_w_data  out  WIDTH  to macro W0_data

Behaviour:
- **Reset** (reset_n=0 at a clock edge):
  - State goes to INIT if INIT_EN=1, else READY.
  - init counter=0; init_done=0.
  - r_resp_valid=0; r_resp_data=0; bypass flag=0.
  - While reset_n is low, all outputs are held at these values and sram_r_en=sram_w_en=0.
  - Reset mid-INIT restarts the clear at address 0.
  - Reset mid-read drops the pending response: no r_resp_valid is issued.
- **INIT state:**
  - r_req_ready=0 and w_req_ready=0.
  - Each cycle: sram_w_en=1, sram_w_addr=counter, sram_w_data=0, sram_r_en=0.
  - The counter increments every cycle.
  - On the write of address DEPTH-1, go to READY next cycle and set init_done=1 (registered).
  - INIT takes exactly DEPTH cycles.
- **READY state:**
  - r_req_ready=1 and w_req_ready=1 every cycle; requests are fully pipelined.
  - At most one read and one write per cycle.
- **Write:**
  - On w_req_valid & w_req_ready: sram_w_en=1, sram_w_addr=w_req_addr, sram_w_data=w_req_data, combinationally in the same cycle.
  - Otherwise sram_w_en=0.
- **Read:**
  - On r_req_valid & r_req_ready (cycle T): sram_r_en=1 and sram_r_addr=r_req_addr in cycle T.
  - In cycle T+1: r_resp_valid=1.
- **Read data selection (cycle T+1):**
  - If a write to the same address fired in cycle T: r_resp_data = the write data captured in T (new-data semantics; a bypass register captures it).
  - Otherwise r_resp_data = sram_r_data.
  - A write fired in T+1 to the same address does not affect the T+1 response.
- **Hold:**
  - The value presented at T+1 is latched into a hold register at the end of T+1.
  - From T+2 onward, r_resp_data is driven from the hold register, not the macro, so later writes to that address do not disturb it.
  - r_resp_valid=0 until the next accepted read.
- **Back-to-back reads** (T and T+1): responses in T+1 and T+2; each uses its own address/bypass decision.
- **Idle cycles:** sram_r_addr=0 and sram_w_addr/sram_w_data=0 when the corresponding enable is 0.

Test Plan:
- Release reset -> init_done rises exactly 128 cycles later; sram_w_en=1 with addresses 0..127 and data 0; both readies 0 throughout; a read of addr 5 afterwards returns 0.
- Write addr 0x12 data 0x1_2345_6789_ABCD, read addr 0x12 two cycles later -> r_resp_valid one cycle after acceptance with data 0x1_2345_6789_ABCD.
- Write and read addr 0x40 in the same cycle with data 0x7FFFF_FFFF_FFFF (51 ones) -> response next cycle = 0x7FFFF_FFFF_FFFF (bypass), not the old 0.
- Read addr 3 (holds 0xAA), then write addr 3 = 0xBB over the next 3 cycles with no new read -> r_resp_data stays 0xAA and r_resp_valid pulses once.
- Reads on 4 consecutive cycles at addresses 1,2,3,127 -> 4 consecutive response pulses with matching data, in order.
- Assert reset_n=0 at init counter 60, then release -> clear restarts at address 0; init_done after 128 more cycles; a pending read accepted just before reset yields no response.
